// File: rtl/boot_pkg.sv
// Shared types and header field layout for the bootloader command engine.
// Header word: {wr[31], addr[30:16], ndata[15:0]}, received little-endian.
package boot_pkg;

    typedef enum logic [2:0] {
        HDR,
        WR,
        RD_REQ,
        RD_WAIT,
        RD_SEND
    } state_t;

    localparam int HDR_WR_BIT   = 31;
    localparam int HDR_ADDR_LSB = 16;
    localparam int HDR_ADDR_W   = 15;
    localparam int HDR_NDATA_W  = 16;

    function automatic logic hdr_is_wr(input logic [31:0] hdr);
        return hdr[HDR_WR_BIT];
    endfunction

endpackage

// File: rtl/boot_cmd_engine_if.sv
// UART byte streams plus IMEM/DMEM ports of the bootloader engine.
// master = the engine, slave = the UART/memory side.
interface boot_cmd_engine_if #(
    parameter int IMEM_AW = 10,
    parameter int DMEM_AW = 10
);
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic               dmem_re;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [31:0]        dmem_rdata;
    logic               cpu_hold;

    modport master (
        input  rx_data, rx_valid, tx_ready, dmem_rdata,
        output tx_data, tx_valid, imem_we, imem_addr, imem_wdata,
               dmem_re, dmem_addr, cpu_hold
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, dmem_rdata,
        input  tx_data, tx_valid, imem_we, imem_addr, imem_wdata,
               dmem_re, dmem_addr, cpu_hold
    );
endinterface

// File: rtl/boot_byte_packer.sv
// Packs RX bytes into 32-bit little-endian words; word_done is combinational on the 4th byte.
// Latency 0 (word presented with the 4th byte); no backpressure, bytes are taken when byte_vld.
module boot_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    input  logic        clear,
    output logic [1:0]  byte_cnt,
    output logic        word_done,
    output logic [31:0] word_dat
);
    // Only the first three bytes need storing; the fourth is used straight off the bus.
    logic [23:0] sr;

    assign word_done = byte_vld && (byte_cnt == 2'd3);
    assign word_dat  = {byte_dat, sr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= 2'd0;
            sr       <= 24'h0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
        end else if (byte_vld) begin
            byte_cnt <= byte_cnt + 2'd1;
            sr       <= {byte_dat, sr[23:8]};
        end
    end
endmodule

// File: rtl/boot_cmd_engine.sv
// Bootloader command responder: RX headers drive IMEM word writes or DMEM reads streamed to TX.
// Write lands one cycle after the 4th byte; read word goes out 2 cycles after RD_REQ, held until tx_ready.
module boot_cmd_engine
    import boot_pkg::*;
#(
    parameter int IMEM_AW        = 10,
    parameter int DMEM_AW        = 10,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    boot_cmd_engine_if.master bus
);
    localparam int AW = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t             state;
    logic [AW-1:0]      addr;
    logic [15:0]        remaining;
    logic [TW-1:0]      timer;
    logic [31:0]        tx_sr;
    logic [1:0]         tx_idx;
    logic               imem_we_q;
    logic [IMEM_AW-1:0] imem_addr_q;
    logic [31:0]        imem_wdata_q;

    logic [1:0]  byte_cnt;
    logic        word_done;
    logic [31:0] word_dat;
    logic        accept;
    logic        counting;
    logic        timeout;

    // Bytes arriving while a read is in flight are dropped before the packer.
    assign accept   = bus.rx_valid && (state == HDR || state == WR);
    assign counting = (state == HDR && byte_cnt != 2'd0) || state == WR;
    assign timeout  = (TIMEOUT_CYCLES != 0) && counting && !bus.rx_valid &&
                      (timer == TW'(TIMEOUT_CYCLES - 1));

    boot_byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_vld  (accept),
        .byte_dat  (bus.rx_data),
        .clear     (timeout),
        .byte_cnt  (byte_cnt),
        .word_done (word_done),
        .word_dat  (word_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (bus.rx_valid || !counting || timeout) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HDR;
            addr         <= '0;
            remaining    <= 16'd0;
            tx_sr        <= 32'h0;
            tx_idx       <= 2'd0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'h0;
        end else begin
            imem_we_q <= 1'b0;
            case (state)
                HDR: begin
                    if (word_done) begin
                        addr      <= word_dat[HDR_ADDR_LSB +: AW];
                        remaining <= word_dat[HDR_NDATA_W-1:0];
                        if (word_dat[HDR_NDATA_W-1:0] != 16'd0)
                            state <= hdr_is_wr(word_dat) ? WR : RD_REQ;
                    end
                end
                WR: begin
                    if (timeout) begin
                        state <= HDR;
                    end else if (word_done) begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= addr[IMEM_AW-1:0];
                        imem_wdata_q <= word_dat;
                        addr         <= addr + AW'(1);
                        remaining    <= remaining - 16'd1;
                    end else if (imem_we_q && remaining == 16'd0) begin
                        // Leave WR only after the last write so cpu_hold covers it.
                        state <= HDR;
                    end
                end
                RD_REQ: state <= RD_WAIT;
                RD_WAIT: begin
                    tx_sr  <= bus.dmem_rdata;
                    tx_idx <= 2'd0;
                    state  <= RD_SEND;
                end
                RD_SEND: begin
                    if (bus.tx_ready) begin
                        if (tx_idx == 2'd3) begin
                            addr      <= addr + AW'(1);
                            remaining <= remaining - 16'd1;
                            state     <= (remaining == 16'd1) ? HDR : RD_REQ;
                        end else begin
                            tx_sr  <= {8'h0, tx_sr[31:8]};
                            tx_idx <= tx_idx + 2'd1;
                        end
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

    assign bus.tx_valid   = (state == RD_SEND);
    assign bus.tx_data    = tx_sr[7:0];
    assign bus.dmem_re    = (state == RD_REQ);
    assign bus.dmem_addr  = addr[DMEM_AW-1:0];
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.cpu_hold   = !(state == HDR && byte_cnt == 2'd0);
endmodule

// File: tb/tb_boot_cmd_engine.sv
// Scoreboard bench for boot_cmd_engine: commands push expected IMEM writes / TX bytes, a monitor pops them.
module tb_boot_cmd_engine;
    localparam int AW = 10;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    boot_cmd_engine_if #(.IMEM_AW(AW), .DMEM_AW(AW)) bus ();

    boot_cmd_engine #(.IMEM_AW(AW), .DMEM_AW(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    int          errors = 0;
    int          checks = 0;
    wr_t         exp_wr[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] wbuf[$];
    logic [31:0] dmem[0:(1<<AW)-1];
    int          re_cnt = 0;
    bit          stall_mode = 0;
    bit          dre_s;
    logic [AW-1:0] dre_addr_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // DMEM model: 1-cycle synchronous read
    initial forever begin
        @(posedge clk);
        #1;
        if (dre_s) bus.dmem_rdata = dmem[dre_addr_s];
    end

    // TX sink: random ready, or a fixed 50-cycle stall per byte
    initial begin
        automatic bit v;
        automatic int wcnt = 0;
        forever begin
            @(negedge clk);
            v = bus.tx_valid;
            @(posedge clk);
            #1;
            if (stall_mode) begin
                if (v && bus.tx_ready) begin
                    wcnt = 0;
                    bus.tx_ready = 1'b0;
                end else begin
                    if (bus.tx_valid) wcnt++;
                    else wcnt = 0;
                    bus.tx_ready = (wcnt >= 50);
                end
            end else begin
                wcnt = 0;
                bus.tx_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor
    initial begin
        automatic bit         prev_stall = 0;
        automatic logic [7:0] prev_dat = 8'h0;
        wr_t w;
        forever begin
            @(negedge clk);
            dre_s      = bus.dmem_re;
            dre_addr_s = bus.dmem_addr;
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                if (bus.dmem_re) re_cnt++;
                if (bus.imem_we) begin
                    check("hold_during_write", bus.cpu_hold, 1);
                    if (exp_wr.size() == 0) begin
                        check("unexpected_imem_we", 1, 0);
                    end else begin
                        w = exp_wr.pop_front();
                        check("imem_addr", bus.imem_addr, w.addr);
                        check("imem_wdata", bus.imem_wdata, w.data);
                    end
                end
                if (prev_stall) begin
                    check("tx_valid_held", bus.tx_valid, 1);
                    check("tx_data_stable", bus.tx_data, prev_dat);
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    if (exp_tx.size() == 0) check("unexpected_tx", bus.tx_data, 0);
                    else check("tx_byte", bus.tx_data, exp_tx.pop_front());
                end
                prev_stall = bus.tx_valid && !bus.tx_ready;
                prev_dat   = bus.tx_data;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    function automatic logic [31:0] mk_hdr(input bit wr, input int addr, input int n);
        return {wr, addr[14:0], n[15:0]};
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (exp_wr.size() == 0 && exp_tx.size() == 0 && !bus.cpu_hold) return;
        end
        check("idle_wait_expired", 1, 0);
    endtask

    // Words to write are taken from wbuf; address wraps in the IMEM word space.
    task automatic do_write(input int addr, input int n);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.addr = AW'(addr + i);
            w.data = wbuf[i];
            exp_wr.push_back(w);
        end
        send_word(mk_hdr(1'b1, addr, n));
        for (int i = 0; i < n; i++) send_word(wbuf[i]);
        wait_idle();
    endtask

    task automatic fill_wbuf(input int n);
        wbuf.delete();
        for (int i = 0; i < n; i++) wbuf.push_back($urandom);
    endtask

    task automatic do_read(input int addr, input int n, input bit stray);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            d = dmem[AW'(addr + i)];
            for (int k = 0; k < 4; k++) exp_tx.push_back(d[8*k +: 8]);
        end
        re_cnt = 0;
        send_word(mk_hdr(1'b0, addr, n));
        if (stray) begin
            repeat (20) @(posedge clk);
            send_byte(8'hAA);
        end
        wait_idle();
        check("dmem_re_count", re_cnt, n);
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk);
        check({tag, "_tx_valid"}, bus.tx_valid, 0);
        check({tag, "_imem_we"}, bus.imem_we, 0);
        check({tag, "_dmem_re"}, bus.dmem_re, 0);
        check({tag, "_cpu_hold"}, bus.cpu_hold, 0);
    endtask

    initial begin
        wr_t w;
        rst_n          = 1'b0;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h0;
        bus.tx_ready   = 1'b0;
        bus.dmem_rdata = 32'h0;
        for (int i = 0; i < (1 << AW); i++) dmem[i] = $urandom;
        repeat (3) @(posedge clk);
        check_quiet("reset");
        check("reset_tx_data", bus.tx_data, 0);
        check("reset_imem_addr", bus.imem_addr, 0);
        check("reset_imem_wdata", bus.imem_wdata, 0);
        check("reset_dmem_addr", bus.dmem_addr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Write 3 words at address 5 (header bytes 03 00 05 80)
        wbuf = '{32'h11111111, 32'h22222222, 32'h33333333};
        do_write(5, 3);
        check_quiet("after_write");

        // Read 2 words from address 0 (header bytes 02 00 00 00)
        dmem[0] = 32'hDEADBEEF;
        dmem[1] = 32'h0000CAFE;
        do_read(0, 2, 1'b0);

        // Stalled TX with a stray RX byte that must be dropped
        stall_mode = 1;
        do_read(0, 2, 1'b1);
        stall_mode = 0;

        // ndata = 0 header, then a normal one
        do_write(5, 0);
        repeat (20) @(posedge clk);
        check_quiet("ndata0");
        fill_wbuf(1);
        do_write(9, 1);

        // Timeout in HDR with a partial word
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (TO + 10) @(posedge clk);
        check_quiet("hdr_timeout");
        fill_wbuf(1);
        do_write(100, 1);

        // Timeout in WR: only the first of two words is written
        fill_wbuf(2);
        w.addr = AW'(200);
        w.data = wbuf[0];
        exp_wr.push_back(w);
        send_word(mk_hdr(1'b1, 200, 2));
        send_word(wbuf[0]);
        send_byte(8'h55);
        send_byte(8'h66);
        repeat (TO + 10) @(posedge clk);
        check_quiet("wr_timeout");
        fill_wbuf(1);
        do_write(300, 1);

        // Address wrap at the top of IMEM
        fill_wbuf(2);
        do_write((1 << AW) - 1, 2);

        // Reset mid-word
        send_byte(8'h01);
        send_byte(8'h00);
        @(posedge clk);
        #1 rst_n = 1'b0;
        check_quiet("rst_midword");
        @(posedge clk);
        #1 rst_n = 1'b1;
        fill_wbuf(1);
        do_write(42, 1);

        // Reset during a stalled read: the TX byte is abandoned
        stall_mode = 1;
        for (int k = 0; k < 4; k++) exp_tx.push_back(dmem[3][8*k +: 8]);
        send_word(mk_hdr(1'b0, 3, 1));
        repeat (30) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_tx.delete();
        check_quiet("rst_midread");
        stall_mode = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_read(7, 1, 1'b0);

        // Randomized commands
        for (int it = 0; it < 20; it++) begin
            automatic int n    = $urandom_range(0, 4);
            automatic int addr = ($urandom_range(0, 3) == 0) ?
                                 ((1 << AW) - $urandom_range(1, 3)) : int'($urandom_range(0, 32767));
            if ($urandom_range(0, 1) == 1) begin
                fill_wbuf(n);
                do_write(addr, n);
            end else begin
                do_read(addr, n, 1'b0);
            end
        end

        repeat (5) @(posedge clk);
        check("leftover_writes", exp_wr.size(), 0);
        check("leftover_tx", exp_tx.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
